// File: rtl/mux_scan_capture_pkg.sv
// Shared types and defaults for the 8:1 mux scan sequencer.
package mux_scan_capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int unsigned NUM_CH_DEF   = 8;
  localparam int unsigned SEL_W_DEF    = $clog2(NUM_CH_DEF);
  localparam int unsigned SETTLE_DEF   = 1;
  localparam int unsigned SCAN_LEN_DEF = NUM_CH_DEF * (SETTLE_DEF + 1);

  // Cycles from the start edge to the edge that raises word_valid.
  function automatic int unsigned scan_len(input int unsigned num_ch, input int unsigned settle);
    return num_ch * (settle + 1);
  endfunction

endpackage

// File: rtl/mux_scan_capture_if.sv
// Mux select/sample lines plus the word handshake toward the consumer.
interface mux_scan_capture_if #(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
);
  logic              start;
  logic              continuous;
  logic [SEL_W-1:0]  sel;
  logic              mux_out;
  logic              busy;
  logic [NUM_CH-1:0] word;
  logic              word_valid;
  logic              word_ready;

  modport master (
    input  start, continuous, mux_out, word_ready,
    output sel, busy, word, word_valid
  );

  modport slave (
    output start, continuous, mux_out, word_ready,
    input  sel, busy, word, word_valid
  );
endinterface

// File: rtl/mux_scan_capture_scan_settle_counter.sv
// Loadable down-counter holding each select value SETTLE extra cycles.
module scan_settle_counter #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);
  localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE);

  logic [CNT_W-1:0] cnt;

  assign zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (en && !zero) begin
      cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

// File: rtl/mux_scan_capture.sv
// Steps the mux select through all channels, samples each after settling,
// and offers the packed word over a valid/ready handshake.
module mux_scan_capture
  import mux_scan_capture_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  mux_scan_capture_if.master  bus
);
  localparam int SEL_W = $clog2(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  state_t            state_q, state_nxt;
  logic [SEL_W-1:0]  sel_q, sel_nxt;
  logic [NUM_CH-1:0] shadow_q, shadow_nxt;
  logic [NUM_CH-1:0] word_q, word_nxt;
  logic              valid_q, valid_nxt;
  logic              cnt_load, cnt_en, cnt_zero;

  scan_settle_counter #(.SETTLE(SETTLE)) u_settle (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .zero (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      shadow_q <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      sel_q    <= sel_nxt;
      shadow_q <= shadow_nxt;
      word_q   <= word_nxt;
      valid_q  <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    sel_nxt    = sel_q;
    shadow_nxt = shadow_q;
    word_nxt   = word_q;
    valid_nxt  = valid_q;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_nxt  = SCAN;
          sel_nxt    = '0;
          shadow_nxt = '0;
          cnt_load   = 1'b1;
        end
      end

      SCAN: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          shadow_nxt[sel_q] = bus.mux_out;
          if (sel_q != LAST_SEL) begin
            sel_nxt  = sel_q + SEL_W'(1);
            cnt_load = 1'b1;
          end else begin
            // The last bit goes straight into word, bypassing the shadow register.
            word_nxt  = shadow_nxt;
            valid_nxt = 1'b1;
            sel_nxt   = '0;
            state_nxt = HOLD;
          end
        end
      end

      HOLD: begin
        if (valid_q && bus.word_ready) begin
          valid_nxt = 1'b0;
          if (bus.continuous) begin
            state_nxt  = SCAN;
            sel_nxt    = '0;
            shadow_nxt = '0;
            cnt_load   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.sel        = sel_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.word       = word_q;
  assign bus.word_valid = valid_q;
endmodule

// File: tb/tb_mux_scan_capture.sv
// Directed bench: two sequencers (SETTLE=1 and SETTLE=0) driving real 8:1 muxes,
// words checked by a scoreboard monitor at each handshake.
module tb_mux_scan_capture;
  import mux_scan_capture_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] x;
  logic [7:0] x0;
  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [7:0] q1[$];
  logic [7:0] q0[$];

  always #5 clk = ~clk;

  mux_scan_capture_if #(.NUM_CH(8)) bus ();
  mux_scan_capture_if #(.NUM_CH(8)) bus_z ();

  assign bus.mux_out   = x[bus.sel];
  assign bus_z.mux_out = x0[bus_z.sel];

  mux_scan_capture #(.NUM_CH(8), .SETTLE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  mux_scan_capture #(.NUM_CH(8), .SETTLE(0)) dut_z (
    .clk (clk),
    .rst (rst),
    .bus (bus_z.master)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard monitors: a handshake is visible one half-cycle before the accepting edge.
  always @(negedge clk) begin
    if (!rst && bus.word_valid && bus.word_ready) begin
      if (q1.size() == 0) check("word1_unexpected", {24'd0, bus.word}, 32'hFFFF_FFFF);
      else check("word1", {24'd0, bus.word}, {24'd0, q1.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst && bus_z.word_valid && bus_z.word_ready) begin
      if (q0.size() == 0) check("word0_unexpected", {24'd0, bus_z.word}, 32'hFFFF_FFFF);
      else check("word0", {24'd0, bus_z.word}, {24'd0, q0.pop_front()});
    end
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.word_valid && n < 2 * scan_len(8, 1));
    check(name, {31'd0, bus.word_valid}, 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    x   = 8'hD5;
    x0  = 8'h01;
    bus.start = 1'b0;   bus.continuous = 1'b0;   bus.word_ready = 1'b1;
    bus_z.start = 1'b0; bus_z.continuous = 1'b0; bus_z.word_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_sel",   {29'd0, bus.sel}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("rst_word",  {24'd0, bus.word}, 32'd0);
    check("rst_valid", {31'd0, bus.word_valid}, 32'd0);
    @(posedge clk); #1;

    // 1: single scan, ready high; sel holds each value two cycles
    q1.push_back(8'hD5);
    pulse_start();
    for (int unsigned k = 0; k < 16; k++) begin
      @(negedge clk);
      check($sformatf("t1_sel_%0d", k), {29'd0, bus.sel}, k / 2);
      if (k == 15) check("t1_valid_early", {31'd0, bus.word_valid}, 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    check("t1_valid_edge16", {31'd0, bus.word_valid}, 32'd1);
    check("t1_busy_hold", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    check("t1_valid_drop", {31'd0, bus.word_valid}, 32'd0);
    check("t1_idle", {31'd0, bus.busy}, 32'd0);
    check("t1_word_kept", {24'd0, bus.word}, 32'hD5);
    @(posedge clk); #1;

    // 2: backpressure, start ignored while holding
    bus.word_ready = 1'b0;
    q1.push_back(8'hD5);
    pulse_start();
    wait_valid("t2_valid");
    for (int k = 0; k < 5; k++) begin
      bus.start = 1'b1;
      check($sformatf("t2_word_%0d", k), {24'd0, bus.word}, 32'hD5);
      check($sformatf("t2_busy_%0d", k), {31'd0, bus.busy}, 32'd1);
      check($sformatf("t2_vld_%0d", k), {31'd0, bus.word_valid}, 32'd1);
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.word_ready = 1'b1;
    @(negedge clk);
    check("t2_valid_drop", {31'd0, bus.word_valid}, 32'd0);
    check("t2_idle", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(negedge clk);
    check("t2_no_queued", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;

    // 3: continuous mode, second scan restarts on the handshake edge
    x = 8'hFF;
    bus.continuous = 1'b1;
    q1.push_back(8'hFF);
    q1.push_back(8'hF7);
    pulse_start();
    wait_valid("t3_valid1");
    x = 8'hF7;
    @(negedge clk);
    check("t3_rescan_busy", {31'd0, bus.busy}, 32'd1);
    check("t3_rescan_sel", {29'd0, bus.sel}, 32'd0);
    check("t3_rescan_valid", {31'd0, bus.word_valid}, 32'd0);
    bus.continuous = 1'b0;
    wait_valid("t3_valid2");
    @(negedge clk);
    check("t3_idle", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;

    // 4: reset mid-scan discards the partial word
    x = 8'hD5;
    pulse_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.sel != 3'd4 && n < 40);
    check("t4_reach_sel4", {29'd0, bus.sel}, 32'd4);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t4_sel", {29'd0, bus.sel}, 32'd0);
    check("t4_busy", {31'd0, bus.busy}, 32'd0);
    check("t4_word", {24'd0, bus.word}, 32'd0);
    check("t4_valid", {31'd0, bus.word_valid}, 32'd0);
    @(posedge clk); #1;
    q1.push_back(8'hD5);
    pulse_start();
    wait_valid("t4_valid_after");
    repeat (2) @(negedge clk);

    // 5: SETTLE=0, one channel per cycle
    @(posedge clk); #1;
    q0.push_back(8'h01);
    bus_z.start = 1'b1;
    @(posedge clk);
    #1 bus_z.start = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("t5_sel_%0d", k), {29'd0, bus_z.sel}, k);
      if (k == 7) check("t5_valid_early", {31'd0, bus_z.word_valid}, 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    check("t5_valid_edge8", {31'd0, bus_z.word_valid}, 32'd1);
    repeat (2) @(negedge clk);
    check("t5_idle", {31'd0, bus_z.busy}, 32'd0);

    check("q1_drained", q1.size(), 32'd0);
    check("q0_drained", q0.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
